// File: rtl/logic_unit_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : logic_unit_arbiter
// Description : Round-robin arbiter/sequencer sharing one combinational
//               16-bit logic unit (AND/OR/XOR/NOT) among NREQ requesters.
//               One operation in flight: IDLE -> EXEC -> RESP.
//               Build option LOGIC_UNIT_ARBITER_FIXED_PRIO_EN selects fixed
//               lowest-index-wins priority instead of round-robin.
// Revision    : 1.0 - initial release
// ============================================================================
module logic_unit_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 16,
  parameter int IDW   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid_i,
  output logic [NREQ-1:0]       req_ready_o,
  input  logic [NREQ*WIDTH-1:0] req_a_i,
  input  logic [NREQ*WIDTH-1:0] req_b_i,
  input  logic [NREQ*3-1:0]     req_code_i,
  output logic [WIDTH-1:0]      lu_a_o,
  output logic [WIDTH-1:0]      lu_b_o,
  output logic [2:0]            lu_code_o,
  input  logic [WIDTH-1:0]      lu_c_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [WIDTH-1:0]      rsp_data_o,
  output logic [IDW-1:0]        rsp_id_o,
  output logic                  rsp_err_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [2:0]       code_q, code_d;
  logic [IDW-1:0]   id_q, id_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [IDW-1:0]   rsp_id_q, rsp_id_d;
  logic             rsp_err_q, rsp_err_d;
`ifndef LOGIC_UNIT_ARBITER_FIXED_PRIO_EN
  logic [IDW-1:0]   ptr_q, ptr_d;
`endif

  logic             gnt_vld;
  logic [IDW-1:0]   gnt_idx;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [2:0]       sel_code;
  logic             code_legal;

  // Grant search: lowest index wins (fixed) or first valid from ptr upward (round-robin)
  always_comb begin : p_grant
    int idx;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx     = 0;
`ifdef LOGIC_UNIT_ARBITER_FIXED_PRIO_EN
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_valid_i[k]) begin
        gnt_vld = 1'b1;
        gnt_idx = IDW'(k);
      end
    end
`else
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!gnt_vld && req_valid_i[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = IDW'(idx);
      end
    end
`endif
  end

  // Mux the granted requester's operands and opcode
  always_comb begin
    sel_a    = '0;
    sel_b    = '0;
    sel_code = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (IDW'(i) == gnt_idx) begin
        sel_a    = req_a_i[i*WIDTH +: WIDTH];
        sel_b    = req_b_i[i*WIDTH +: WIDTH];
        sel_code = req_code_i[i*3 +: 3];
      end
    end
  end

  // Ready only toward the granted requester, and only while idle
  always_comb begin
    req_ready_o = '0;
    if (state_q == ST_IDLE && gnt_vld) req_ready_o[gnt_idx] = 1'b1;
  end

  // Opcode legality: only the four bitwise operations are recognised
  always_comb begin
    case (code_q)
      3'b000, 3'b001, 3'b010, 3'b100: code_legal = 1'b1;
      default:                        code_legal = 1'b0;
    endcase
  end

  // Next-state and datapath update for the IDLE/EXEC/RESP sequence
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    code_d      = code_q;
    id_d        = id_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
    rsp_err_d   = rsp_err_q;
`ifndef LOGIC_UNIT_ARBITER_FIXED_PRIO_EN
    ptr_d       = ptr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        // In IDLE a valid grant is by construction an accepted request
        if (gnt_vld) begin
          a_d     = sel_a;
          b_d     = sel_b;
          code_d  = sel_code;
          id_d    = gnt_idx;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        rsp_valid_d = 1'b1;
        rsp_id_d    = id_q;
        if (code_legal) begin
          rsp_data_d = lu_c_i;
          rsp_err_d  = 1'b0;
        end else begin
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
        end
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          state_d     = ST_IDLE;
`ifndef LOGIC_UNIT_ARBITER_FIXED_PRIO_EN
          ptr_d = (id_q == IDW'(NREQ - 1)) ? '0 : id_q + 1'b1;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      code_q      <= '0;
      id_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
      rsp_err_q   <= 1'b0;
`ifndef LOGIC_UNIT_ARBITER_FIXED_PRIO_EN
      ptr_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      code_q      <= code_d;
      id_q        <= id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
      rsp_err_q   <= rsp_err_d;
`ifndef LOGIC_UNIT_ARBITER_FIXED_PRIO_EN
      ptr_q       <= ptr_d;
`endif
    end
  end

  // The logic unit always sees the latched operation, so its inputs only move on acceptance
  assign lu_a_o      = a_q;
  assign lu_b_o      = b_q;
  assign lu_code_o   = code_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign rsp_id_o    = rsp_id_q;
  assign rsp_err_o   = rsp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_logic_unit_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_logic_unit_arbiter
// Description : Directed self-checking bench for logic_unit_arbiter, with a
//               behavioural model of the shared logic unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_logic_unit_arbiter;
  localparam int NREQ  = 4;
  localparam int WIDTH = 16;
  localparam int IDW   = 2;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [NREQ-1:0]       req_valid = '0;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a = '0;
  logic [NREQ*WIDTH-1:0] req_b = '0;
  logic [NREQ*3-1:0]     req_code = '0;
  logic [WIDTH-1:0]      lu_a, lu_b, lu_c;
  logic [2:0]            lu_code;
  logic                  rsp_valid;
  logic                  rsp_ready = 1'b0;
  logic [WIDTH-1:0]      rsp_data;
  logic [IDW-1:0]        rsp_id;
  logic                  rsp_err;

  int errs   = 0;
  int checks = 0;

  logic_unit_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_a_i(req_a), .req_b_i(req_b), .req_code_i(req_code),
    .lu_a_o(lu_a), .lu_b_o(lu_b), .lu_code_o(lu_code), .lu_c_i(lu_c),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_data_o(rsp_data), .rsp_id_o(rsp_id), .rsp_err_o(rsp_err)
  );

  always #5 clk = ~clk;

  // Shared logic unit; illegal codes return garbage that must be ignored
  always_comb begin
    case (lu_code)
      3'b000:  lu_c = lu_a & lu_b;
      3'b001:  lu_c = lu_a | lu_b;
      3'b010:  lu_c = lu_a ^ lu_b;
      3'b100:  lu_c = ~lu_a;
      default: lu_c = 16'hDEAD;
    endcase
  end

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0; req_valid = '0; rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic set_req(input int id, input logic [15:0] a, input logic [15:0] b,
                         input logic [2:0] code);
    req_a[id*WIDTH +: WIDTH] = a;
    req_b[id*WIDTH +: WIDTH] = b;
    req_code[id*3 +: 3]      = code;
  endtask

  // Drives one request from an idle negedge and returns the captured response
  task automatic issue(input int id, input logic [15:0] a, input logic [15:0] b,
                       input logic [2:0] code, output logic [15:0] d,
                       output logic [1:0] rid, output logic err, output logic ok);
    int n;
    ok = 1'b0; d = '0; rid = '0; err = 1'b0;
    set_req(id, a, b, code);
    req_valid = 4'b0001 << id;
    rsp_ready = 1'b1;
    #1;
    n = 0;
    while (!req_ready[id] && n < 20) begin @(negedge clk); #1; n++; end
    if (req_ready[id]) begin
      @(posedge clk); #1;
      req_valid = '0;
      n = 0;
      while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
      if (rsp_valid) begin
        d = rsp_data; rid = rsp_id; err = rsp_err; ok = 1'b1;
      end
      @(negedge clk);
    end else begin
      req_valid = '0;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0; req_valid = '0; rsp_ready = 1'b0;
    #1;
    checks++; if (rsp_valid !== 1'b0) begin errs++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
    checks++; if (rsp_err !== 1'b0) begin errs++; $display("FAIL reset_rsp_err got %b exp 0", rsp_err); end
    checks++; if (rsp_data !== 16'h0) begin errs++; $display("FAIL reset_rsp_data got %h exp 0000", rsp_data); end
    checks++; if (rsp_id !== 2'd0) begin errs++; $display("FAIL reset_rsp_id got %0d exp 0", rsp_id); end
    checks++; if ({lu_a, lu_b, lu_code} !== 35'h0) begin errs++; $display("FAIL reset_lu got a=%h b=%h c=%b exp 0", lu_a, lu_b, lu_code); end
    checks++; if (req_ready !== 4'b0000) begin errs++; $display("FAIL reset_req_ready got %b exp 0000", req_ready); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_and();
    apply_reset();
    set_req(1, 16'hF0F0, 16'h0FF0, 3'b000);
    req_valid = 4'b0010; rsp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errs++; $display("FAIL and_req_ready got %b exp 0010", req_ready); end
    @(posedge clk); #1;
    req_valid = '0;
    checks++; if (rsp_valid !== 1'b0) begin errs++; $display("FAIL and_exec_valid got %b exp 0", rsp_valid); end
    checks++; if ({lu_a, lu_b, lu_code} !== {16'hF0F0, 16'h0FF0, 3'b000}) begin errs++; $display("FAIL and_lu_inputs got a=%h b=%h c=%b exp F0F0 0FF0 000", lu_a, lu_b, lu_code); end
    checks++; if (req_ready !== 4'b0000) begin errs++; $display("FAIL and_exec_ready got %b exp 0000", req_ready); end
    @(posedge clk); #1;
    checks++; if ({rsp_valid, rsp_data, rsp_id, rsp_err} !== {1'b1, 16'h00F0, 2'd1, 1'b0}) begin errs++; $display("FAIL and_rsp got v=%b d=%h id=%0d e=%b exp 1 00F0 1 0", rsp_valid, rsp_data, rsp_id, rsp_err); end
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 1'b0) begin errs++; $display("FAIL and_rsp_clear got %b exp 0", rsp_valid); end
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    int exp_id, waited;
    logic [15:0] exp_d;
    apply_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, 16'(16'h1111 * (i + 1)), 16'h0000, 3'b001);
    rsp_ready = 1'b1;
    req_valid = 4'b1111;
    for (int n = 0; n < 5; n++) begin
`ifdef LOGIC_UNIT_ARBITER_FIXED_PRIO_EN
      exp_id = 0;
`else
      exp_id = n % NREQ;
`endif
      exp_d = 16'(16'h1111 * (exp_id + 1));
      #1;
      waited = 0;
      while (req_ready == 4'b0000 && waited < 10) begin @(negedge clk); #1; waited++; end
      checks++; if (req_ready !== (4'b0001 << exp_id)) begin errs++; $display("FAIL rr_grant%0d got %b exp %b", n, req_ready, 4'b0001 << exp_id); end
      if (n > 0) begin
        checks++; if (waited !== 0) begin errs++; $display("FAIL rr_throughput%0d got %0d idle cycles exp 0", n, waited); end
      end
      @(posedge clk);
      @(negedge clk);
      @(negedge clk);
      checks++; if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 2'(exp_id), exp_d}) begin errs++; $display("FAIL rr_rsp%0d got v=%b id=%0d d=%h exp 1 %0d %h", n, rsp_valid, rsp_id, rsp_data, exp_id, exp_d); end
      @(negedge clk);
    end
    req_valid = '0;
    @(negedge clk);
  endtask

  task automatic test_not_illegal();
    logic [15:0] d; logic [1:0] rid; logic err, ok;
    apply_reset();
    issue(2, 16'h1234, 16'h0000, 3'b100, d, rid, err, ok);
    checks++; if ({ok, d, rid, err} !== {1'b1, 16'hEDCB, 2'd2, 1'b0}) begin errs++; $display("FAIL not_op got ok=%b d=%h id=%0d e=%b exp 1 EDCB 2 0", ok, d, rid, err); end
    issue(0, 16'h5A5A, 16'hFFFF, 3'b011, d, rid, err, ok);
    checks++; if ({ok, d, rid, err} !== {1'b1, 16'h0000, 2'd0, 1'b1}) begin errs++; $display("FAIL illegal_op got ok=%b d=%h id=%0d e=%b exp 1 0000 0 1", ok, d, rid, err); end
    #1;
    checks++; if ({rsp_valid, rsp_err} !== 2'b00) begin errs++; $display("FAIL illegal_clear got v=%b e=%b exp 0 0", rsp_valid, rsp_err); end
  endtask

  task automatic test_backpressure();
    apply_reset();
    set_req(0, 16'h00FF, 16'h0F0F, 3'b010);
    set_req(1, 16'h0001, 16'h0001, 3'b000);
    rsp_ready = 1'b0;
    req_valid = 4'b0011;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errs++; $display("FAIL bp_first_grant got %b exp 0001", req_ready); end
    @(posedge clk); #1;
    req_valid = 4'b0010;
    @(negedge clk);
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      checks++; if ({rsp_valid, rsp_data, rsp_id, rsp_err, req_ready} !== {1'b1, 16'h0FF0, 2'd0, 1'b0, 4'b0000}) begin errs++; $display("FAIL bp_hold%0d got v=%b d=%h id=%0d e=%b rdy=%b exp 1 0FF0 0 0 0000", c, rsp_valid, rsp_data, rsp_id, rsp_err, req_ready); end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++; if ({rsp_valid, req_ready} !== {1'b0, 4'b0010}) begin errs++; $display("FAIL bp_next_grant got v=%b rdy=%b exp 0 0010", rsp_valid, req_ready); end
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    checks++; if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 2'd1, 16'h0001}) begin errs++; $display("FAIL bp_second_rsp got v=%b id=%0d d=%h exp 1 1 0001", rsp_valid, rsp_id, rsp_data); end
    @(negedge clk);
  endtask

  task automatic test_reset_exec();
    logic [15:0] d; logic [1:0] rid; logic err, ok;
    apply_reset();
    issue(1, 16'h0F0F, 16'hFFFF, 3'b000, d, rid, err, ok);
    checks++; if ({ok, d, rid} !== {1'b1, 16'h0F0F, 2'd1}) begin errs++; $display("FAIL rx_pre_op got ok=%b d=%h id=%0d exp 1 0F0F 1", ok, d, rid); end
    set_req(2, 16'hBEEF, 16'h0000, 3'b001);
    set_req(3, 16'h3C3C, 16'hFFFF, 3'b000);
    set_req(0, 16'h0000, 16'h0000, 3'b000);
    req_valid = 4'b0100;
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    checks++; if (lu_a !== 16'hBEEF) begin errs++; $display("FAIL rx_in_exec got lu_a=%h exp BEEF", lu_a); end
    rst_n = 1'b0;
    #1;
    checks++; if ({rsp_valid, lu_a, lu_code} !== {1'b0, 16'h0000, 3'b000}) begin errs++; $display("FAIL rx_async got v=%b lu_a=%h c=%b exp 0 0000 000", rsp_valid, lu_a, lu_code); end
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin errs++; $display("FAIL rx_no_rsp got %b exp 0", rsp_valid); end
    rst_n = 1'b1;
    req_valid = 4'b1001;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errs++; $display("FAIL rx_ptr_restart got %b exp 0001", req_ready); end
    req_valid = 4'b1000;
    #1;
    checks++; if (req_ready !== 4'b1000) begin errs++; $display("FAIL rx_req3_ready got %b exp 1000", req_ready); end
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    checks++; if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 2'd3, 16'h3C3C}) begin errs++; $display("FAIL rx_req3_rsp got v=%b id=%0d d=%h exp 1 3 3C3C", rsp_valid, rsp_id, rsp_data); end
    @(negedge clk);
  endtask

  task automatic test_or_xor();
    logic [15:0] d; logic [1:0] rid; logic err, ok;
    apply_reset();
    issue(1, 16'hAAAA, 16'h5555, 3'b001, d, rid, err, ok);
    checks++; if ({ok, d, err} !== {1'b1, 16'hFFFF, 1'b0}) begin errs++; $display("FAIL or_op got ok=%b d=%h e=%b exp 1 FFFF 0", ok, d, err); end
    issue(1, 16'hAAAA, 16'h5555, 3'b010, d, rid, err, ok);
    checks++; if ({ok, d, err} !== {1'b1, 16'hFFFF, 1'b0}) begin errs++; $display("FAIL xor_op got ok=%b d=%h e=%b exp 1 FFFF 0", ok, d, err); end
    issue(3, 16'hAAAA, 16'hAAAA, 3'b010, d, rid, err, ok);
    checks++; if ({ok, d, rid, err} !== {1'b1, 16'h0000, 2'd3, 1'b0}) begin errs++; $display("FAIL xor_zero got ok=%b d=%h id=%0d e=%b exp 1 0000 3 0", ok, d, rid, err); end
  endtask

  initial begin
    test_reset();
    test_and();
    test_round_robin();
    test_not_illegal();
    test_backpressure();
    test_reset_exec();
    test_or_xor();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
